// File: rtl/sys_arr_skew_feeder_pkg.sv
// rtl/sys_arr_skew_feeder_pkg.sv - shared types, defaults and helpers for the systolic skew feeder
package sys_arr_skew_feeder_pkg;

    localparam int DEF_SYS_ARR_SIZE = 32;
    localparam int DEF_IN_PRECISION = 16;

    typedef enum logic [1:0] {
        S_FD_IDLE  = 2'd0,
        S_FD_FEED  = 2'd1,
        S_FD_FLUSH = 2'd2,
        S_FD_DONE  = 2'd3
    } feeder_state_e;

    // Width needed to hold the values 0..max_val, never narrower than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sys_arr_skew_feeder_if.sv
// rtl/sys_arr_skew_feeder_if.sv - BRAM-side beat inputs and array-edge outputs of the skew feeder
interface sys_arr_skew_feeder_if
    import sys_arr_skew_feeder_pkg::*;
#(
    parameter int SYS_ARR_SIZE         = DEF_SYS_ARR_SIZE,
    parameter int SYS_ARR_IN_PRECISION = DEF_IN_PRECISION,
    parameter int SYS_K_BEATS          = SYS_ARR_SIZE
);
    localparam int SLICE_WIDTH     = SYS_ARR_SIZE * SYS_ARR_IN_PRECISION;
    localparam int BRAM_DOUT_WIDTH = 2 * SLICE_WIDTH;
    localparam int BEAT_CNT_WIDTH  = cnt_width(SYS_K_BEATS);

    logic                       sys_valid_i;
    logic                       sys_data_sel_i;
    logic [BRAM_DOUT_WIDTH-1:0] bram_a_dout_i;
    logic [BRAM_DOUT_WIDTH-1:0] bram_b_dout_i;
    logic [SLICE_WIDTH-1:0]     sys_a_o;
    logic [SLICE_WIDTH-1:0]     sys_b_o;
    logic [SYS_ARR_SIZE-1:0]    sys_a_valid_o;
    logic [SYS_ARR_SIZE-1:0]    sys_b_valid_o;
    logic                       spad_mat_ab_rd_done_o;
    logic [BEAT_CNT_WIDTH-1:0]  beat_count_o;
    logic                       overflow_o;

    modport master (
        output sys_valid_i, sys_data_sel_i, bram_a_dout_i, bram_b_dout_i,
        input  sys_a_o, sys_b_o, sys_a_valid_o, sys_b_valid_o,
        input  spad_mat_ab_rd_done_o, beat_count_o, overflow_o
    );

    modport slave (
        input  sys_valid_i, sys_data_sel_i, bram_a_dout_i, bram_b_dout_i,
        output sys_a_o, sys_b_o, sys_a_valid_o, sys_b_valid_o,
        output spad_mat_ab_rd_done_o, beat_count_o, overflow_o
    );

endinterface

// File: rtl/sys_arr_skew_feeder_lane.sv
// rtl/sys_arr_skew_feeder_lane.sv - one skew lane: DEPTH-stage shift register of data plus valid
module sys_skew_lane #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic             valid_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s]  <= '0;
                valid_q[s] <= 1'b0;
            end
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int s = 1; s < DEPTH; s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sys_arr_skew_feeder.sv
// rtl/sys_arr_skew_feeder.sv - selects a K-slice per beat, skews it onto the array edges, tracks tile completion
module sys_arr_skew_feeder
    import sys_arr_skew_feeder_pkg::*;
#(
    parameter int SYS_ARR_SIZE         = DEF_SYS_ARR_SIZE,
    parameter int SYS_ARR_IN_PRECISION = DEF_IN_PRECISION,
    parameter int SYS_K_BEATS          = SYS_ARR_SIZE
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    sys_arr_skew_feeder_if.slave bus
);
    localparam int P               = SYS_ARR_IN_PRECISION;
    localparam int SLICE_WIDTH     = SYS_ARR_SIZE * P;
    localparam int BEAT_CNT_WIDTH  = cnt_width(SYS_K_BEATS);
    localparam int FLUSH_CNT_WIDTH = cnt_width(SYS_ARR_SIZE);
    localparam logic [BEAT_CNT_WIDTH-1:0]  K_LAST     = BEAT_CNT_WIDTH'(SYS_K_BEATS);
    localparam logic [BEAT_CNT_WIDTH-1:0]  CNT_ONE    = BEAT_CNT_WIDTH'(1);
    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LAST = FLUSH_CNT_WIDTH'(SYS_ARR_SIZE - 1);

    feeder_state_e               state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d, beat_cnt_next;
    logic [FLUSH_CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
    logic                        done_q, overflow_q;
    logic                        beat_ok;
    logic [SLICE_WIDTH-1:0]      slice_a, slice_b, lane_a_in, lane_b_in, edge_a, edge_b;
    logic [SYS_ARR_SIZE-1:0]     edge_a_valid, edge_b_valid;

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        beat_ok       = 1'b0;
        beat_cnt_next = beat_cnt_q;
        case (state_q)
            S_FD_IDLE, S_FD_DONE, S_FD_FEED: begin
                if (bus.sys_valid_i) begin
                    beat_ok = 1'b1;
                    // A beat outside FEED always opens a fresh tile
                    if (state_q != S_FD_FEED)       beat_cnt_next = CNT_ONE;
                    else if (beat_cnt_q != K_LAST)  beat_cnt_next = beat_cnt_q + 1'b1;
                    beat_cnt_d  = beat_cnt_next;
                    flush_cnt_d = '0;
                    state_d     = (beat_cnt_next == K_LAST) ? S_FD_FLUSH : S_FD_FEED;
                end
            end
            S_FD_FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == FLUSH_LAST) state_d = S_FD_DONE;
            end
            default: state_d = S_FD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_FD_IDLE;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= (state_d == S_FD_DONE);
            overflow_q  <= overflow_q | (bus.sys_valid_i && (state_q == S_FD_FLUSH));
        end
    end

    assign slice_a   = bus.sys_data_sel_i ? bus.bram_a_dout_i[2*SLICE_WIDTH-1 -: SLICE_WIDTH]
                                          : bus.bram_a_dout_i[SLICE_WIDTH-1:0];
    assign slice_b   = bus.sys_data_sel_i ? bus.bram_b_dout_i[2*SLICE_WIDTH-1 -: SLICE_WIDTH]
                                          : bus.bram_b_dout_i[SLICE_WIDTH-1:0];
    // Rejected or absent beats enter the lanes as zero bubbles
    assign lane_a_in = beat_ok ? slice_a : '0;
    assign lane_b_in = beat_ok ? slice_b : '0;

    for (genvar i = 0; i < SYS_ARR_SIZE; i++) begin : g_lane
        sys_skew_lane #(.DEPTH(i + 1), .WIDTH(P)) u_lane_a (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .data_i  (lane_a_in[i*P +: P]),
            .valid_i (beat_ok),
            .data_o  (edge_a[i*P +: P]),
            .valid_o (edge_a_valid[i])
        );
        sys_skew_lane #(.DEPTH(i + 1), .WIDTH(P)) u_lane_b (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .data_i  (lane_b_in[i*P +: P]),
            .valid_i (beat_ok),
            .data_o  (edge_b[i*P +: P]),
            .valid_o (edge_b_valid[i])
        );
    end

    assign bus.sys_a_o               = edge_a;
    assign bus.sys_b_o               = edge_b;
    assign bus.sys_a_valid_o         = edge_a_valid;
    assign bus.sys_b_valid_o         = edge_b_valid;
    assign bus.spad_mat_ab_rd_done_o = done_q;
    assign bus.beat_count_o          = beat_cnt_q;
    assign bus.overflow_o            = overflow_q;

endmodule

// File: tb/tb_sys_arr_skew_feeder.sv
// tb/tb_sys_arr_skew_feeder.sv - directed and random checks of the skew feeder against a cycle-history model
module tb_sys_arr_skew_feeder;
    localparam int N  = 4;
    localparam int P  = 16;
    localparam int K  = 4;
    localparam int SW = N * P;
    localparam int BW = 2 * SW;
    localparam int HIST = 2048;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    sys_arr_skew_feeder_if #(.SYS_ARR_SIZE(N), .SYS_ARR_IN_PRECISION(P), .SYS_K_BEATS(K)) bus ();

    sys_arr_skew_feeder #(.SYS_ARR_SIZE(N), .SYS_ARR_IN_PRECISION(P), .SYS_K_BEATS(K)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: per-cycle history of what entered the lanes, plus tile bookkeeping
    int n = 0;
    int rst_cycle = -1;
    int last_beat = -1;
    int tile_beats = 0;
    bit m_ovf = 1'b0;
    logic [SW-1:0] inj_a [HIST];
    logic [SW-1:0] inj_b [HIST];
    bit            inj_v [HIST];

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] pat(input int beat, input bit sel, input int base);
        logic [SW-1:0] s;
        logic [BW-1:0] w;
        for (int l = 0; l < N; l++) s[l*P +: P] = 16'(base + 16 * beat + l);
        w = rnd_word();
        if (sel) w[BW-1:SW] = s;
        else     w[SW-1:0]  = s;
        return w;
    endfunction

    task automatic step(input bit rst, input bit v, input bit sel,
                        input logic [BW-1:0] a, input logic [BW-1:0] b);
        bit in_flush, acc;
        int idx;
        logic [SW-1:0] ea, eb;
        logic [N-1:0]  ev;
        if (n >= HIST) begin
            $display("FAIL history_overflow cycle=%0d", n);
            $fatal(1, "history exhausted");
        end
        reset_i = rst;
        bus.sys_valid_i = v;
        bus.sys_data_sel_i = sel;
        bus.bram_a_dout_i = a;
        bus.bram_b_dout_i = b;
        // A full tile flushes for N cycles after its last beat, then sits done
        in_flush = (tile_beats == K) && (n <= last_beat + N);
        acc = !rst && v && !in_flush;
        if (rst) begin
            rst_cycle = n; last_beat = -1; tile_beats = 0; m_ovf = 1'b0;
        end else begin
            if (v && in_flush) m_ovf = 1'b1;
            if (acc) begin
                tile_beats = (tile_beats == K) ? 1 : tile_beats + 1;
                last_beat = n;
            end
        end
        inj_v[n] = acc;
        inj_a[n] = acc ? (sel ? a[BW-1:SW] : a[SW-1:0]) : '0;
        inj_b[n] = acc ? (sel ? b[BW-1:SW] : b[SW-1:0]) : '0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) begin
            idx = n - i;
            ev[i]          = (idx > rst_cycle) ? inj_v[idx] : 1'b0;
            ea[i*P +: P]   = (idx > rst_cycle) ? inj_a[idx][i*P +: P] : '0;
            eb[i*P +: P]   = (idx > rst_cycle) ? inj_b[idx][i*P +: P] : '0;
        end
        chk("sys_a_o", bus.sys_a_o, ea);
        chk("sys_b_o", bus.sys_b_o, eb);
        chk("sys_a_valid_o", SW'(bus.sys_a_valid_o), SW'(ev));
        chk("sys_b_valid_o", SW'(bus.sys_b_valid_o), SW'(ev));
        chk("done", SW'(bus.spad_mat_ab_rd_done_o),
            SW'((tile_beats == K) && (n + 1 >= last_beat + N + 1)));
        chk("beat_count", SW'(bus.beat_count_o), SW'(tile_beats));
        chk("overflow", SW'(bus.overflow_o), SW'(m_ovf));
        n++;
    endtask

    task automatic idle(input int cnt);
        for (int c = 0; c < cnt; c++) step(1'b0, 1'b0, 1'($urandom), rnd_word(), rnd_word());
    endtask

    task automatic beat(input bit sel);
        step(1'b0, 1'b1, sel, rnd_word(), rnd_word());
    endtask

    task automatic basic_tile();
        for (int b = 0; b < K; b++) begin
            step(1'b0, 1'b1, 1'(b % 2), pat(b, 1'(b % 2), 0), pat(b, 1'(b % 2), 'h100));
            if (b == 0) chk("tile_b_lane0_t1", SW'(bus.sys_b_o[0 +: P]), SW'(16'h0100));
            if (b == 2) chk("tile_a_lane2_t3", SW'(bus.sys_a_o[2*P +: P]), SW'(16'h0002));
        end
        idle(3);
        chk("tile_a_lane3_t7", SW'(bus.sys_a_o[3*P +: P]), SW'(16'h0033));
        chk("tile_done_low_t7", SW'(bus.spad_mat_ab_rd_done_o), SW'(0));
        idle(1);
        chk("tile_done_t8", SW'(bus.spad_mat_ab_rd_done_o), SW'(1));
    endtask

    initial begin
        reset_i = 1'b1;
        bus.sys_valid_i = 1'b0;
        bus.sys_data_sel_i = 1'b0;
        bus.bram_a_dout_i = '0;
        bus.bram_b_dout_i = '0;

        // Reset with random inputs
        for (int c = 0; c < 3; c++) step(1'b1, 1'($urandom), 1'($urandom), rnd_word(), rnd_word());
        chk("reset_beat_count", SW'(bus.beat_count_o), SW'(0));

        // Basic tile, then stay in done
        basic_tile();
        idle(2);

        // Two-cycle gap between beats 1 and 2
        beat(1'b0); beat(1'b1); idle(2);
        chk("bubble_lane1_t4", SW'(bus.sys_a_valid_o[1]), SW'(0));
        beat(1'b0);
        chk("bubble_lane1_t5", SW'(bus.sys_a_valid_o[1]), SW'(0));
        beat(1'b1);
        idle(3);
        chk("bubble_done_low_t9", SW'(bus.spad_mat_ab_rd_done_o), SW'(0));
        idle(1);
        chk("bubble_done_t10", SW'(bus.spad_mat_ab_rd_done_o), SW'(1));

        // Beat during flush is dropped and flagged
        for (int b = 0; b < K; b++) beat(1'(b));
        beat(1'b1);
        chk("ovf_set", SW'(bus.overflow_o), SW'(1));
        idle(1);
        chk("ovf_no_lane0_valid", SW'(bus.sys_a_valid_o[0]), SW'(0));
        idle(2);
        chk("ovf_done_t8", SW'(bus.spad_mat_ab_rd_done_o), SW'(1));

        // Back-to-back tile from done
        beat(1'b0);
        chk("b2b_done_low", SW'(bus.spad_mat_ab_rd_done_o), SW'(0));
        chk("b2b_count_one", SW'(bus.beat_count_o), SW'(1));
        chk("b2b_lane0_valid", SW'(bus.sys_a_valid_o[0]), SW'(1));
        chk("ovf_sticky", SW'(bus.overflow_o), SW'(1));
        for (int b = 1; b < K; b++) beat(1'(b));
        idle(N + 2);

        // Reset mid-feed, then a clean tile
        step(1'b1, 1'b0, 1'b0, rnd_word(), rnd_word());
        beat(1'b0); beat(1'b1);
        step(1'b1, 1'b1, 1'b0, rnd_word(), rnd_word());
        chk("midrst_valids", SW'(bus.sys_a_valid_o), SW'(0));
        chk("midrst_data", bus.sys_a_o, SW'(0));
        chk("midrst_ovf", SW'(bus.overflow_o), SW'(0));
        basic_tile();

        // Random traffic with occasional resets
        for (int c = 0; c < 300; c++)
            step(($urandom % 60) == 0, ($urandom % 4) != 0, 1'($urandom), rnd_word(), rnd_word());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
